sreg_rx: RTL and testbench
==========================

SREG_RX -- requirements
Module: sreg_rx

Interface
REQ-001 Parameter DATA_W, default 42: captured word width in bits.
REQ-002 Parameter LANES, default 2: serial lanes per shift cycle; DATA_W SHALL be an integer multiple of LANES.
REQ-003 clk  input  1  single clock; all logic SHALL be rising-edge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle request to read out one word from the shift-register chain.
REQ-006 sreg_in  input  LANES  serial data from the chain tail; valid the cycle after shift is high.
REQ-007 shift  output  1  shift enable to the chain.
REQ-008 data_out  output  DATA_W  captured word, registered.
REQ-009 data_valid  output  1  data_out holds an unconsumed word.
REQ-010 data_ready  input  1  consumer accepts data_out when data_valid and data_ready are both high.
REQ-011 busy  output  1  high whenever the state is not IDLE.
REQ-012 overrun  output  1  sticky flag: start was ignored.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, SHIFT, LAST and WAIT.
REQ-014 Define N = DATA_W/LANES (21 by default); the shift counter SHALL be ceil(log2(N)) bits wide and SHALL count 0..N-1 with no wrap beyond N-1.
REQ-015 IDLE with start=1 SHALL go to SHIFT next cycle, clear the counter and clear the capture register.
REQ-016 In SHIFT, shift SHALL be 1 for exactly N consecutive cycles; after count N-1 the FSM SHALL go to LAST.
REQ-017 shift SHALL be registered, high only in SHIFT, and deasserted in LAST, WAIT and IDLE.
REQ-018 sreg_in SHALL be sampled on every cycle after a cycle with shift=1, i.e. N samples, the final one in LAST.
REQ-019 Capture order SHALL be MSB-first: cap <= {cap[DATA_W-LANES-1:0], sreg_in}; the first sample ends in data_out[DATA_W-1:DATA_W-LANES].
REQ-020 In LAST, if data_valid=0 or (data_valid and data_ready), the completed word SHALL load data_out, data_valid SHALL be 1 next cycle, and the FSM SHALL go to IDLE; otherwise it SHALL go to WAIT.
REQ-021 WAIT SHALL hold the complete word with shift=0 and load data_out under the REQ-020 condition, then go to IDLE.
REQ-022 Latency: start sampled at cycle 0 -> shift high in cycles 1..N -> data_valid high from cycle N+2 (23 by default) when the output register is empty.
REQ-023 data_valid SHALL clear on handshake unless a new word loads in the same cycle, in which case it SHALL stay 1 with the new data.
REQ-024 data_out and data_valid SHALL be stable while data_valid=1 and data_ready=0.
REQ-025 start in any state other than IDLE SHALL be ignored and SHALL set overrun; only rst clears overrun.
REQ-026 A new start SHALL be accepted in IDLE while data_valid=1 (one word of buffering).
REQ-027 start and data_ready in the same IDLE cycle SHALL both take effect.

Reset
REQ-028 With rst=1 at a clk edge, the state SHALL be IDLE and the counter 0 after that edge.
REQ-029 With rst=1 at a clk edge, after that edge: shift=0, data_out=0, data_valid=0, busy=0, overrun=0.
REQ-030 rst mid-readout SHALL abort the frame and discard the partial word; shift SHALL be 0 the cycle after rst is sampled.
REQ-031 rst SHALL take priority over start and over the handshake.
REQ-032 After rst deasserts, the first start SHALL behave per REQ-022.

Verification
REQ-033 Chain model loaded with 42'h26B4B4F692A, start pulse, data_ready=1 -> shift high 21 cycles, data_valid at cycle 23, data_out=42'h26B4B4F692A.
REQ-034 data_ready=0, two back-to-back frames (0x155_5555_5555, then 0x2AA_AAAA_AAAA) -> FSM reaches WAIT with shift=0; first word is held; data_ready=1 -> first word, then second word the next cycle.
REQ-035 start pulsed at cycle 5 of SHIFT -> overrun=1 and the frame completes unchanged; second start in IDLE -> normal frame, overrun stays 1.
REQ-036 rst asserted at cycle 10 of SHIFT -> shift=0 and data_valid=0 next cycle; a following frame with 42'h3FF_FFFF_FFFF returns the exact value.
REQ-037 Handshake in the same cycle LAST loads a new word -> data_valid stays 1 and no word is lost or duplicated (scoreboard count matches).

Source files
------------

// File: rtl/sreg_rx.sv
// sreg_rx: reads one word out of an external serial shift-register chain.
//
// On a start request in IDLE the block raises shift for N = DATA_W/LANES
// consecutive cycles. It captures LANES bits of the chain tail (sreg_in) on
// each cycle that follows a shift cycle, MSB-first, and presents the
// finished word on a one-deep registered valid/ready output.
//
// Ports
//   clk         in   clock, rising edge
//   rst         in   synchronous active-high reset
//   start       in   one-cycle request to read out one word
//   sreg_in     in   LANES-bit serial data, valid the cycle after shift
//   shift       out  registered shift enable to the chain
//   data_out    out  DATA_W-bit captured word, registered
//   data_valid  out  data_out holds an unconsumed word
//   data_ready  in   consumer accepts data_out when data_valid is also high
//   busy        out  FSM is not idle
//   overrun     out  sticky: a start arrived while busy and was dropped
//
// Parameters
//   DATA_W  captured word width; must be an integer multiple of LANES
//   LANES   serial lanes shifted per cycle
module sreg_rx #(
  parameter int unsigned DATA_W = 42,
  parameter int unsigned LANES  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LANES-1:0]  sreg_in,
  output logic              shift,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              busy,
  output logic              overrun
);

  // Number of shift cycles per word.
  localparam int unsigned N    = DATA_W / LANES;
  // A single-beat word still needs a one-bit counter.
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StLast,
    StWait
  } state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]   cap_q, cap_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic                data_valid_q, data_valid_d;
  logic                shift_q, shift_d;
  logic                overrun_q, overrun_d;

  logic [DATA_W-1:0]   cap_shifted;
  logic [DATA_W-1:0]   load_word;
  logic                sample;
  logic                load;
  logic                load_ok;
  logic                handshake;

  // Capture register with the current sreg_in appended at the LSB end; the
  // first sample therefore ends up in the top LANES bits.
  if (LANES == DATA_W) begin : gen_single_beat
    assign cap_shifted = sreg_in;
  end else begin : gen_multi_beat
    assign cap_shifted = {cap_q[DATA_W-LANES-1:0], sreg_in};
  end

  // The chain presents data one cycle after each shift cycle. Shift is high
  // for every SHIFT cycle, so the sample cycles are SHIFT with a non-zero
  // count followed by the single LAST cycle.
  assign sample = ((state_q == StShift) && (cnt_q != '0)) || (state_q == StLast);

  assign handshake = data_valid_q && data_ready;
  // The output register can take a new word if it is empty or being drained.
  assign load_ok   = !data_valid_q || data_ready;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cap_d        = cap_q;
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    overrun_d    = overrun_q;
    load         = 1'b0;
    load_word    = cap_q;

    if (start && (state_q != StIdle)) begin
      overrun_d = 1'b1;
    end

    if (sample) begin
      cap_d = cap_shifted;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StShift;
          cnt_d   = '0;
          cap_d   = '0;
        end
      end
      StShift: begin
        // Hold the count at N-1; LAST takes over from there.
        if (cnt_q == CntLast) begin
          state_d = StLast;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StLast: begin
        // The final sample is still on sreg_in, so load the shifted value.
        load_word = cap_shifted;
        if (load_ok) begin
          load    = 1'b1;
          state_d = StIdle;
        end else begin
          state_d = StWait;
        end
      end
      StWait: begin
        load_word = cap_q;
        if (load_ok) begin
          load    = 1'b1;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // A load in the handshake cycle keeps valid high with the new word.
    if (load) begin
      data_out_d   = load_word;
      data_valid_d = 1'b1;
    end else if (handshake) begin
      data_valid_d = 1'b0;
    end

    // Shift is registered from the next state so it lines up with SHIFT.
    shift_d = (state_d == StShift);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      cap_q        <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      shift_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cap_q        <= cap_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      shift_q      <= shift_d;
      overrun_q    <= overrun_d;
    end
  end

  assign shift      = shift_q;
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign busy       = (state_q != StIdle);
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_sreg_rx.sv
// Self-checking bench for sreg_rx: a behavioural shift-chain model drives
// sreg_in, and a scoreboard of expected words checks every output handshake.
module tb_sreg_rx;

  localparam int unsigned DATA_W = 42;
  localparam int unsigned LANES  = 2;
  localparam int unsigned N      = DATA_W / LANES;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              data_ready = 1'b0;
  logic [LANES-1:0]  sreg_in = '0;
  logic              shift;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              busy;
  logic              overrun;

  sreg_rx #(
    .DATA_W (DATA_W),
    .LANES  (LANES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .sreg_in    (sreg_in),
    .shift      (shift),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Chain model state.
  logic [DATA_W-1:0] frame_word = '0;
  int                pos = 0;
  logic              shift_seen = 1'b0;

  // Scoreboard.
  logic [DATA_W-1:0] exp_q[$];
  int                n_words = 0;

  // Observations from the most recent negedge.
  logic              shift_obs = 1'b0;
  logic              dv_obs = 1'b0;
  logic              busy_obs = 1'b0;
  logic              ovr_obs = 1'b0;
  logic [DATA_W-1:0] dout_obs = '0;

  // Results of run_watch.
  int                w_nsh, w_fsh, w_lsh, w_fdv;
  logic [DATA_W-1:0] w_dout;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: observe mid-cycle, score any handshake, then let the chain
  // model present the next chunk after each shift cycle.
  task automatic cycle();
    @(negedge clk);
    shift_obs  = shift;
    dv_obs     = data_valid;
    busy_obs   = busy;
    ovr_obs    = overrun;
    dout_obs   = data_out;
    shift_seen = shift;
    if (!rst && data_valid === 1'b1 && data_ready) begin
      chk("hs_pending", 64'(exp_q.size() > 0), 64'(1));
      if (exp_q.size() > 0) begin
        chk("hs_word", 64'(data_out), 64'(exp_q.pop_front()));
        n_words++;
      end
    end
    @(posedge clk);
    #1;
    if (shift_seen === 1'b1) begin
      if (pos < int'(N)) begin
        sreg_in = frame_word[DATA_W-1-pos*LANES -: LANES];
      end
      pos++;
    end else begin
      pos = 0;
    end
  endtask

  task automatic begin_frame(input logic [DATA_W-1:0] w);
    frame_word = w;
    exp_q.push_back(w);
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic run_watch(input int cycles, input int start_at, input int rst_at);
    w_nsh  = 0;
    w_fsh  = 0;
    w_lsh  = 0;
    w_fdv  = 0;
    w_dout = '0;
    for (int k = 1; k <= cycles; k++) begin
      start = (k == start_at);
      rst   = (k == rst_at);
      cycle();
      if (k == rst_at) exp_q.delete();
      if (shift_obs) begin
        w_nsh++;
        if (w_fsh == 0) w_fsh = k;
        w_lsh = k;
      end
      if (dv_obs && w_fdv == 0) begin
        w_fdv  = k;
        w_dout = dout_obs;
      end
    end
    start = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      cycle();
      done = !busy_obs;
    end
    chk({tag, "_idle_timeout"}, 64'(done), 64'(1));
  endtask

  task automatic drain(input string tag);
    bit done = 1'b0;
    data_ready = 1'b1;
    for (int i = 0; i < 300 && !done; i++) begin
      cycle();
      done = (exp_q.size() == 0) && !busy_obs && !dv_obs;
    end
    chk({tag, "_drain_timeout"}, 64'(done), 64'(1));
  endtask

  initial begin
    logic [63:0]       r;
    logic [DATA_W-1:0] wa, wb;
    int                w0, n_acc, since;
    bit                stray;

    // Reset state.
    rst = 1'b1;
    cycle();
    cycle();
    chk("rst_shift", 64'(shift), 64'(0));
    chk("rst_dout", 64'(data_out), 64'(0));
    chk("rst_dv", 64'(data_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_ovr", 64'(overrun), 64'(0));
    rst = 1'b0;
    cycle();

    // Single frame with the consumer always ready: latency and value.
    data_ready = 1'b1;
    begin_frame(42'h26B4B4F692A);
    run_watch(N + 3, 0, 0);
    chk("t1_nshift", 64'(w_nsh), 64'(N));
    chk("t1_first_shift", 64'(w_fsh), 64'(1));
    chk("t1_last_shift", 64'(w_lsh), 64'(N));
    chk("t1_first_dv", 64'(w_fdv), 64'(N + 2));
    chk("t1_dout", 64'(w_dout), 64'(42'h26B4B4F692A));
    chk("t1_dv_cleared", 64'(dv_obs), 64'(0));
    chk("t1_idle", 64'(busy_obs), 64'(0));

    // Back-to-back frames with the consumer stalled.
    data_ready = 1'b0;
    begin_frame(42'h155_5555_5555);
    wait_idle("t2a");
    chk("t2_a_held_dv", 64'(dv_obs), 64'(1));
    begin_frame(42'h2AA_AAAA_AAAA);
    run_watch(N + 4, 0, 0);
    chk("t2_nshift", 64'(w_nsh), 64'(N));
    chk("t2_wait_busy", 64'(busy_obs), 64'(1));
    chk("t2_wait_shift", 64'(shift_obs), 64'(0));
    chk("t2_wait_dv", 64'(dv_obs), 64'(1));
    chk("t2_wait_dout", 64'(dout_obs), 64'(42'h155_5555_5555));
    data_ready = 1'b1;
    cycle();
    chk("t2_out_a", 64'(dout_obs), 64'(42'h155_5555_5555));
    cycle();
    chk("t2_out_b", 64'(dout_obs), 64'(42'h2AA_AAAA_AAAA));
    chk("t2_out_b_dv", 64'(dv_obs), 64'(1));
    cycle();
    chk("t2_dv_cleared", 64'(dv_obs), 64'(0));
    chk("t2_ovr_clear", 64'(ovr_obs), 64'(0));

    // Start during SHIFT is dropped and flagged; the frame is unaffected.
    r  = {$urandom, $urandom};
    wa = r[DATA_W-1:0];
    begin_frame(wa);
    run_watch(N + 3, 5, 0);
    chk("t3_first_dv", 64'(w_fdv), 64'(N + 2));
    chk("t3_dout", 64'(w_dout), 64'(wa));
    chk("t3_ovr", 64'(ovr_obs), 64'(1));
    wait_idle("t3");
    r  = {$urandom, $urandom};
    wb = r[DATA_W-1:0];
    begin_frame(wb);
    run_watch(N + 3, 0, 0);
    chk("t3_second_first_dv", 64'(w_fdv), 64'(N + 2));
    chk("t3_second_dout", 64'(w_dout), 64'(wb));
    chk("t3_ovr_sticky", 64'(ovr_obs), 64'(1));

    // Reset in the middle of SHIFT aborts the frame.
    r = {$urandom, $urandom};
    begin_frame(r[DATA_W-1:0]);
    run_watch(10, 0, 10);
    cycle();
    chk("t4_shift", 64'(shift_obs), 64'(0));
    chk("t4_dv", 64'(dv_obs), 64'(0));
    chk("t4_busy", 64'(busy_obs), 64'(0));
    chk("t4_ovr", 64'(ovr_obs), 64'(0));
    begin_frame(42'h3FF_FFFF_FFFF);
    run_watch(N + 3, 0, 0);
    chk("t4_nshift", 64'(w_nsh), 64'(N));
    chk("t4_first_dv", 64'(w_fdv), 64'(N + 2));
    chk("t4_dout", 64'(w_dout), 64'(42'h3FF_FFFF_FFFF));

    // Handshake in the same cycle LAST loads the next word.
    w0         = n_words;
    data_ready = 1'b0;
    r          = {$urandom, $urandom};
    wa         = r[DATA_W-1:0];
    begin_frame(wa);
    wait_idle("t5a");
    chk("t5_a_held", 64'(dv_obs), 64'(1));
    r  = {$urandom, $urandom};
    wb = r[DATA_W-1:0];
    begin_frame(wb);
    run_watch(N, 0, 0);
    chk("t5_shift_end", 64'(shift_obs), 64'(1));
    chk("t5_a_still", 64'(dout_obs), 64'(wa));
    data_ready = 1'b1;
    cycle();
    chk("t5_out_a", 64'(dout_obs), 64'(wa));
    cycle();
    chk("t5_dv_kept", 64'(dv_obs), 64'(1));
    chk("t5_out_b", 64'(dout_obs), 64'(wb));
    cycle();
    chk("t5_dv_cleared", 64'(dv_obs), 64'(0));
    chk("t5_words", 64'(n_words - w0), 64'(2));
    chk("t5_sb_empty", 64'(exp_q.size()), 64'(0));

    // Randomized traffic: random words, random back-pressure, and stray
    // starts placed only where a frame is known to be shifting.
    w0    = n_words;
    n_acc = 0;
    since = 1000;
    stray = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      data_ready = 1'($urandom_range(0, 1));
      start      = 1'b0;
      if (!busy_obs && since > 1 && n_acc < 10 && $urandom_range(0, 3) == 0) begin
        r          = {$urandom, $urandom};
        frame_word = r[DATA_W-1:0];
        exp_q.push_back(frame_word);
        start = 1'b1;
        since = 0;
        n_acc++;
      end else if (since >= 1 && since <= int'(N) && $urandom_range(0, 15) == 0) begin
        start = 1'b1;
        stray = 1'b1;
      end
      cycle();
      since++;
    end
    start = 1'b0;
    drain("rnd");
    chk("rnd_words", 64'(n_words - w0), 64'(n_acc));
    chk("rnd_sb_empty", 64'(exp_q.size()), 64'(0));
    chk("rnd_ovr", 64'(ovr_obs), 64'(stray));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
